// File: rtl/register_scoreboard.sv
// Write-side hazard scoreboard for the 5-stage MIPS pipeline: tracks pending destination
// registers with forwarding countdowns and drives PC/IF-ID hold and ID/EX bubble controls.
// Optional SCOREBOARD_STATS_EN adds stall_cycles / hazard_events counters.
module register_scoreboard #(
  parameter int NREGS      = 32,
  parameter int LAT_W      = 3,
  parameter int FORWARDING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [4:0]       issue_rd,
  input  logic [LAT_W-1:0] issue_latency,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic             PCWrite,
  output logic             IFID_write,
  output logic             memRegWriteSelection
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      hazard_events
`endif
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [LAT_W-1:0] cnt     [NREGS];
  logic [LAT_W-1:0] cnt_nxt [NREGS];

  logic issue_accept;
  logic wb_clear;
  logic rs_haz;
  logic rt_haz;

  // Reads of $0 never hazard; without forwarding the write-first regfile bypasses a same-cycle writeback.
  function automatic logic src_hazard(input logic [4:0] s);
    logic h;
    h = 1'b0;
    if (s != 5'd0) begin
      if (FORWARDING != 0) h = pending[s] && (cnt[s] != '0);
      else                 h = pending[s] && !(wb_valid && (wb_rd == s));
    end
    return h;
  endfunction

  assign rs_haz = src_hazard(IFID_rs);
  assign rt_haz = src_hazard(IFID_rt);

  assign stall                = rs_haz | rt_haz;
  assign PCWrite              = !stall;
  assign IFID_write           = !stall;
  assign memRegWriteSelection = !stall;

  assign issue_accept = issue_valid && issue_regwrite && !stall && (issue_rd != 5'd0);
  assign wb_clear     = wb_valid && (wb_rd != 5'd0);

  // Per-entry priority: issue > writeback > countdown.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pending_nxt[r] = pending[r];
      cnt_nxt[r]     = (cnt[r] != '0) ? (cnt[r] - LAT_W'(1)) : '0;
      if (wb_clear && (wb_rd == 5'(r))) begin
        pending_nxt[r] = 1'b0;
        cnt_nxt[r]     = '0;
      end
      if (issue_accept && (issue_rd == 5'(r))) begin
        pending_nxt[r] = 1'b1;
        cnt_nxt[r]     = issue_latency;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending <= '0;
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      pending <= pending_nxt;
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic stall_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      hazard_events <= '0;
      stall_q       <= 1'b0;
    end else begin
      stall_q <= stall;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (stall && !stall_q && (hazard_events != '1))
        hazard_events <= hazard_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: one forwarding instance and one
// non-forwarding instance share all inputs; expected values are hand-computed.
module tb_register_scoreboard;

  localparam int LAT_W = 3;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic             issue_regwrite;
  logic [4:0]       issue_rd;
  logic [LAT_W-1:0] issue_latency;
  logic [4:0]       IFID_rs;
  logic [4:0]       IFID_rt;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;

  logic stall, pc_write, ifid_write, mem_sel;
  logic stall_nf, pc_write_nf, ifid_write_nf, mem_sel_nf;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles, stall_cycles_nf;
  logic [15:0] hazard_events, hazard_events_nf;
`endif

  int errors = 0;
  int checks = 0;

  register_scoreboard #(.NREGS(32), .LAT_W(LAT_W), .FORWARDING(1)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_rd(issue_rd), .issue_latency(issue_latency), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall), .PCWrite(pc_write),
    .IFID_write(ifid_write), .memRegWriteSelection(mem_sel)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles), .hazard_events(hazard_events)
`endif
  );

  register_scoreboard #(.NREGS(32), .LAT_W(LAT_W), .FORWARDING(0)) dut_nf (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_rd(issue_rd), .issue_latency(issue_latency), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall_nf), .PCWrite(pc_write_nf),
    .IFID_write(ifid_write_nf), .memRegWriteSelection(mem_sel_nf)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles_nf), .hazard_events(hazard_events_nf)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; issue_valid = 1'b0; issue_regwrite = 1'b0; issue_rd = 5'd0;
    issue_latency = '0; IFID_rs = 5'd0; IFID_rt = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0;
    flush = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = rd; issue_latency = lat;
  endtask

  task automatic drive_random();
    issue_valid = 1'($urandom_range(1)); issue_regwrite = 1'($urandom_range(1));
    issue_rd = 5'($urandom_range(31)); issue_latency = LAT_W'($urandom_range(7));
    IFID_rs = 5'($urandom_range(31)); IFID_rt = 5'($urandom_range(31));
    wb_valid = 1'($urandom_range(1)); wb_rd = 5'($urandom_range(31));
    flush = 1'($urandom_range(1));
  endtask

  task automatic clear_all();
    drive_idle(); flush = 1'b1; tick(); drive_idle();
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic any_nf;

  initial begin
    drive_idle();

    // Reset with random inputs
    rst = 1'b1; drive_random(); tick();
    drive_random(); rst = 1'b1; #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pcwrite", 32'(pc_write), 32'd1);
    check("rst_ifidwrite", 32'(ifid_write), 32'd1);
    check("rst_memsel", 32'(mem_sel), 32'd1);
    check("rst_stall_nf", 32'(stall_nf), 32'd0);
    tick();
    drive_idle(); #1;
    any_nf = 1'b0;
    for (int r = 1; r < 32; r++) begin
      IFID_rs = 5'(r); #1;
      any_nf = any_nf | stall_nf | stall;
    end
    check("rst_no_pending", 32'(any_nf), 32'd0);
`ifdef SCOREBOARD_STATS_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_hazard_events", 32'(hazard_events), 32'd0);
`endif
    drive_idle(); tick();

    // Load-use: rd=9 latency 1 -> exactly one bubble
    drive_issue(5'd9, 3'd1); #1;
    check("lu_issue_cycle", 32'(stall), 32'd0);
    tick(); drive_idle();
    IFID_rs = 5'd10; #1;
    check("lu_unrelated", 32'(stall), 32'd0);
    IFID_rs = 5'd9; #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_pcwrite", 32'(pc_write), 32'd0);
    check("lu_ifidwrite", 32'(ifid_write), 32'd0);
    check("lu_memsel", 32'(mem_sel), 32'd0);
    tick();
    check("lu_release", 32'(stall), 32'd0);
    check("lu_nf_pending", 32'(stall_nf), 32'd1);
    IFID_rs = 5'd10; #1;
    check("lu_unrelated2", 32'(stall), 32'd0);
    IFID_rs = 5'd9; wb_valid = 1'b1; wb_rd = 5'd9; #1;
    check("lu_nf_wb_bypass", 32'(stall_nf), 32'd0);
    tick(); drive_idle(); IFID_rs = 5'd9; #1;
    check("lu_nf_cleared", 32'(stall_nf), 32'd0);
    tick();

    // Multi-cycle: rd=12 latency 4, read via rt; writeback of 12 at cycle 6
    drive_issue(5'd12, 3'd4); tick();
    drive_idle();
    for (int c = 1; c <= 6; c++) begin
      IFID_rt = 5'd12;
      if (c == 6) begin wb_valid = 1'b1; wb_rd = 5'd12; end
      #1;
      check($sformatf("mc_fw_c%0d", c), 32'(stall), (c <= 4) ? 32'd1 : 32'd0);
      check($sformatf("mc_nf_c%0d", c), 32'(stall_nf), (c <= 5) ? 32'd1 : 32'd0);
      tick();
    end
    drive_idle(); IFID_rt = 5'd12; #1;
    check("mc_nf_after_wb", 32'(stall_nf), 32'd0);
    tick();

    // $0 destination never recorded
    drive_issue(5'd0, 3'd5); tick(); drive_idle();
    for (int c = 1; c <= 3; c++) begin
      #1;
      check($sformatf("r0_fw_c%0d", c), 32'(stall), 32'd0);
      check($sformatf("r0_nf_c%0d", c), 32'(stall_nf), 32'd0);
      tick();
    end

    // Issue presented while stalled is not recorded
    drive_issue(5'd5, 3'd3); tick();
    drive_idle(); IFID_rs = 5'd5; drive_issue(5'd6, 3'd3); #1;
    check("stalled_issue_stall", 32'(stall), 32'd1);
    tick(); drive_idle(); IFID_rs = 5'd6; #1;
    check("stalled_issue_fw", 32'(stall), 32'd0);
    check("stalled_issue_nf", 32'(stall_nf), 32'd0);
    clear_all();

    // Collision: issue and writeback to 7 in the same cycle; issue wins
    drive_issue(5'd7, 3'd2); wb_valid = 1'b1; wb_rd = 5'd7; tick();
    drive_idle();
    for (int c = 1; c <= 3; c++) begin
      IFID_rs = 5'd7; #1;
      check($sformatf("col_fw_c%0d", c), 32'(stall), (c <= 2) ? 32'd1 : 32'd0);
      check($sformatf("col_nf_c%0d", c), 32'(stall_nf), 32'd1);
      tick();
    end
    clear_all();

    // Flush during a stall: stall holds in flush cycle, drops next cycle
    drive_issue(5'd7, 3'd4); tick();
    drive_idle(); IFID_rs = 5'd7; flush = 1'b1; #1;
    check("flush_cycle_fw", 32'(stall), 32'd1);
    check("flush_cycle_nf", 32'(stall_nf), 32'd1);
    tick(); flush = 1'b0; #1;
    check("flush_after_fw", 32'(stall), 32'd0);
    check("flush_after_nf", 32'(stall_nf), 32'd0);

    // Flush beats a same-cycle unstalled issue
    drive_idle(); drive_issue(5'd8, 3'd3); flush = 1'b1; tick();
    drive_idle(); IFID_rs = 5'd8; #1;
    check("flush_vs_issue_fw", 32'(stall), 32'd0);
    check("flush_vs_issue_nf", 32'(stall_nf), 32'd0);
    tick();

    // WAW: youngest producer's latency governs
    drive_issue(5'd11, 3'd5); tick();
    drive_issue(5'd11, 3'd1); tick();
    drive_idle(); IFID_rt = 5'd11; #1;
    check("waw_c1", 32'(stall), 32'd1);
    tick();
    check("waw_c2", 32'(stall), 32'd0);
    clear_all();

`ifdef SCOREBOARD_STATS_EN
    // Stats: two load-use stalls plus one 4-cycle stall, flush does not clear
    drive_idle(); rst = 1'b1; tick(); drive_idle();
    for (int k = 0; k < 2; k++) begin
      drive_issue(5'd9, 3'd1); tick();
      drive_idle(); IFID_rs = 5'd9; tick();
      drive_idle(); tick();
    end
    drive_issue(5'd12, 3'd4); tick();
    drive_idle(); IFID_rt = 5'd12;
    for (int c = 0; c < 5; c++) tick();
    drive_idle(); flush = 1'b1; tick(); drive_idle(); #1;
    check("stats_stall_cycles", stall_cycles, 32'd6);
    check("stats_hazard_events", 32'(hazard_events), 32'd3);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
